// File: rtl/serpent_perm_pipe.sv
// Serpent IP/FP bit permutation feeding an elastic valid/ready register pipeline.
// The permutation is pure wiring; the stages carry the permuted block and its tag.
module serpent_perm_pipe #(
  parameter int PIPE_DEPTH = 2,
  parameter int TAG_W      = 4,
  parameter int CNT_W      = 16
) (
  input  logic             i_clk,
  input  logic             i_rst_n,
  input  logic             i_valid,
  input  logic             i_mode,
  input  logic [127:0]     i_data,
  input  logic [TAG_W-1:0] i_tag,
  input  logic             i_out_ready,
  output logic             o_in_ready,
  output logic             o_valid,
  output logic [127:0]     o_data,
  output logic [TAG_W-1:0] o_tag,
  output logic             o_busy,
  output logic [CNT_W-1:0] o_count
);

  logic [127:0]          perm_ip;
  logic [127:0]          perm_fp;
  logic [127:0]          perm_sel;
  logic [PIPE_DEPTH-1:0] valid_reg;
  logic [127:0]          data_reg [PIPE_DEPTH];
  logic [TAG_W-1:0]      tag_reg  [PIPE_DEPTH];
  logic [CNT_W-1:0]      count_reg;
  logic [PIPE_DEPTH:0]   rdy;

  // Bit k = 4i+j of the output (counted from the MSB) comes from column j, row i.
  genvar gi, gj;
  generate
    for (gi = 0; gi < 32; gi++) begin : g_row
      for (gj = 0; gj < 4; gj++) begin : g_col
        assign perm_ip[127-(4*gi+gj)] = i_data[32*gj+gi];
        assign perm_fp[32*gj+gi]      = i_data[127-(4*gi+gj)];
      end
    end
  endgenerate

  assign perm_sel = i_mode ? perm_fp : perm_ip;

  // rdy[n]: stage n may load this cycle (empty, or its contents move on).
  assign rdy[PIPE_DEPTH] = i_out_ready;
  generate
    for (gi = 0; gi < PIPE_DEPTH; gi++) begin : g_rdy
      assign rdy[gi] = !valid_reg[gi] || rdy[gi+1];
    end
  endgenerate

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      valid_reg <= '0;
      count_reg <= '0;
      for (int n = 0; n < PIPE_DEPTH; n++) begin
        data_reg[n] <= '0;
        tag_reg[n]  <= '0;
      end
    end else begin
      if (rdy[0]) begin
        valid_reg[0] <= i_valid;
        if (i_valid) begin
          data_reg[0] <= perm_sel;
          tag_reg[0]  <= i_tag;
        end
      end
      // Payload only changes when a real block arrives, so a stalled output holds.
      for (int n = 1; n < PIPE_DEPTH; n++) begin
        if (rdy[n]) begin
          valid_reg[n] <= valid_reg[n-1];
          if (valid_reg[n-1]) begin
            data_reg[n] <= data_reg[n-1];
            tag_reg[n]  <= tag_reg[n-1];
          end
        end
      end
      if (valid_reg[PIPE_DEPTH-1] && i_out_ready) begin
        count_reg <= count_reg + CNT_W'(1);
      end
    end
  end

  assign o_in_ready = rdy[0];
  assign o_valid    = valid_reg[PIPE_DEPTH-1];
  assign o_data     = data_reg[PIPE_DEPTH-1];
  assign o_tag      = tag_reg[PIPE_DEPTH-1];
  assign o_busy     = |valid_reg;
  assign o_count    = count_reg;

endmodule

// File: tb/tb_serpent_perm_pipe.sv
// Scoreboard bench for serpent_perm_pipe: randomized blocks against an index-arithmetic
// permutation model, with directed vectors, stall, wrap and reset scenarios.
`timescale 1ns/1ps
module tb_serpent_perm_pipe;
  localparam int DEPTH = 3;
  localparam int TAG_W = 4;
  localparam int CNT_W = 8;

  logic             i_clk, i_rst_n, i_valid, i_mode, i_out_ready;
  logic [127:0]     i_data;
  logic [TAG_W-1:0] i_tag;
  logic             o_in_ready, o_valid, o_busy;
  logic [127:0]     o_data;
  logic [TAG_W-1:0] o_tag;
  logic [CNT_W-1:0] o_count;

  serpent_perm_pipe #(.PIPE_DEPTH(DEPTH), .TAG_W(TAG_W), .CNT_W(CNT_W)) dut (
    .i_clk(i_clk), .i_rst_n(i_rst_n), .i_valid(i_valid), .i_mode(i_mode),
    .i_data(i_data), .i_tag(i_tag), .i_out_ready(i_out_ready),
    .o_in_ready(o_in_ready), .o_valid(o_valid), .o_data(o_data), .o_tag(o_tag),
    .o_busy(o_busy), .o_count(o_count)
  );

  typedef struct {
    logic [127:0]     data;
    logic [TAG_W-1:0] tag;
    int               cyc;
  } exp_t;

  exp_t             exp_q[$];
  int               pop_hist[$];
  int               tests = 0;
  int               errors = 0;
  int               cyc = 0;
  int               last_lat = 0;
  int               rdy_mode = 1;
  logic [TAG_W-1:0] tag_ctr = '0;

  initial begin
    i_clk = 1'b0;
    forever #5 i_clk = ~i_clk;
  end

  initial forever begin
    @(posedge i_clk);
    cyc++;
  end

  // Downstream ready: 0 = stalled, 1 = always ready, 2 = random
  initial begin
    i_out_ready = 1'b1;
    forever begin
      @(posedge i_clk);
      #1;
      case (rdy_mode)
        0:       i_out_ready = 1'b0;
        1:       i_out_ready = 1'b1;
        default: i_out_ready = 1'($urandom_range(0, 1));
      endcase
    end
  end

  // Reference: output bit (127-k), k = 4i+j, takes input bit 32j+i.
  function automatic logic [127:0] ip_ref(input logic [127:0] x);
    logic [127:0] r;
    for (int p = 0; p < 128; p++) begin
      int k;
      k = 127 - p;
      r[p] = x[32 * (k % 4) + k / 4];
    end
    return r;
  endfunction

  function automatic logic [127:0] fp_ref(input logic [127:0] x);
    logic [127:0] r;
    for (int i = 0; i < 32; i++)
      for (int j = 0; j < 4; j++)
        r[32 * j + i] = x[127 - (4 * i + j)];
    return r;
  endfunction

  function automatic logic [127:0] rand128();
    return {$urandom(), $urandom(), $urandom(), $urandom()};
  endfunction

  task automatic check(input string name, input logic [127:0] got, input logic [127:0] want);
    tests++;
    if (got !== want) begin
      errors++;
      $display("FAIL %s: got %h, expected %h", name, got, want);
    end
  endtask

  // Monitor: every output handshake is compared against the oldest expected block.
  initial forever begin
    @(negedge i_clk);
    if (i_rst_n && o_valid && i_out_ready) begin
      tests++;
      if (exp_q.size() == 0) begin
        errors++;
        $display("FAIL unexpected_output: got tag %h data %h, expected nothing", o_tag, o_data);
      end else begin
        exp_t e;
        e = exp_q.pop_front();
        last_lat = cyc - e.cyc;
        pop_hist.push_back(cyc);
        if (o_data !== e.data || o_tag !== e.tag) begin
          errors++;
          $display("FAIL out_block: got tag %h data %h, expected tag %h data %h",
                   o_tag, o_data, e.tag, e.data);
        end else begin
          $display("[TB] out tag=%h data=%h lat=%0d", o_tag, o_data, last_lat);
        end
      end
    end
  end

  task automatic send(input logic [127:0] d, input logic m, input logic [127:0] want);
    i_valid = 1'b1;
    i_mode  = m;
    i_data  = d;
    i_tag   = tag_ctr;
    for (int w = 0; w < 500; w++) begin
      @(negedge i_clk);
      if (o_in_ready) begin
        exp_q.push_back('{want, tag_ctr, cyc});
        tag_ctr++;
        @(posedge i_clk);
        #1;
        return;
      end
      @(posedge i_clk);
      #1;
    end
    check("send_timeout", 128'(o_in_ready), 128'(1));
  endtask

  task automatic send_rand(input logic m);
    logic [127:0] d;
    d = rand128();
    send(d, m, m ? fp_ref(d) : ip_ref(d));
  endtask

  task automatic idle();
    i_valid = 1'b0;
  endtask

  task automatic drain();
    for (int w = 0; w < 2000; w++) begin
      @(posedge i_clk);
      #1;
      if (exp_q.size() == 0) return;
    end
    check("drain_timeout", 128'(exp_q.size()), 128'(0));
  endtask

  task automatic do_reset();
    i_rst_n = 1'b0;
    exp_q.delete();
    repeat (2) @(posedge i_clk);
    #1;
    i_rst_n = 1'b1;
  endtask

  initial begin
    logic [127:0] x, y, snap;
    int           acc;
    bit           snap_set;

    i_rst_n = 1'b0; i_valid = 1'b0; i_mode = 1'b0; i_data = '0; i_tag = '0;
    repeat (2) @(posedge i_clk);
    #1;
    check("rst_valid", 128'(o_valid), 128'(0));
    check("rst_busy",  128'(o_busy),  128'(0));
    check("rst_count", 128'(o_count), 128'(0));
    check("rst_data",  o_data,        128'(0));
    check("rst_tag",   128'(o_tag),   128'(0));
    i_rst_n = 1'b1;
    check("rst_in_ready", 128'(o_in_ready), 128'(1));

    // Directed vectors, with unstalled latency
    send(128'h1, 1'b0, 128'h8000_0000_0000_0000_0000_0000_0000_0000);
    idle(); drain();
    check("lat_ip1", 128'(last_lat), 128'(DEPTH));
    send(128'h2, 1'b0, 128'h0800_0000_0000_0000_0000_0000_0000_0000);
    idle(); drain();
    check("lat_ip2", 128'(last_lat), 128'(DEPTH));
    send(128'h8000_0000_0000_0000_0000_0000_0000_0000, 1'b1, 128'h1);
    idle(); drain();
    check("lat_fp", 128'(last_lat), 128'(DEPTH));

    // Round trip: IP then FP must restore the original block
    for (int r = 0; r < 4; r++) begin
      x = rand128();
      y = ip_ref(x);
      send(x, 1'b0, y);
      send(y, 1'b1, x);
    end
    idle(); drain();

    // 100 back-to-back blocks with alternating mode
    do_reset();
    rdy_mode = 1;
    @(posedge i_clk); #1;
    pop_hist.delete();
    for (int n = 0; n < 100; n++) send_rand(1'(n % 2));
    idle(); drain();
    check("b2b_outputs", 128'(pop_hist.size()), 128'(100));
    if (pop_hist.size() == 100) check("b2b_span", 128'(pop_hist[99] - pop_hist[0]), 128'(99));
    check("b2b_count", 128'(o_count), 128'(100));

    // Stalled output with continuous input
    rdy_mode = 0;
    @(posedge i_clk); #1;
    acc = 0; snap_set = 0; snap = '0;
    for (int n = 0; n < 10; n++) begin
      x = rand128();
      i_valid = 1'b1; i_mode = 1'(n % 2); i_data = x; i_tag = tag_ctr;
      @(negedge i_clk);
      if (o_in_ready) begin
        exp_q.push_back('{(n % 2) ? fp_ref(x) : ip_ref(x), tag_ctr, cyc});
        tag_ctr++;
        acc++;
      end
      if (o_valid && !snap_set) begin
        snap = o_data;
        snap_set = 1;
      end
      @(posedge i_clk); #1;
    end
    check("stall_accepted", 128'(acc), 128'(DEPTH));
    check("stall_in_ready", 128'(o_in_ready), 128'(0));
    check("stall_valid",    128'(o_valid), 128'(1));
    check("stall_hold",     o_data, snap);
    idle();
    rdy_mode = 1;
    drain();

    // Random valid/ready traffic
    rdy_mode = 2;
    for (int n = 0; n < 150; n++) begin
      send_rand(1'($urandom_range(0, 1)));
      if ($urandom_range(0, 2) == 0) begin
        idle();
        @(posedge i_clk); #1;
      end
    end
    idle(); drain();

    // Counter wrap
    do_reset();
    for (int n = 0; n < (1 << CNT_W) - 1; n++) begin
      send_rand(1'($urandom_range(0, 1)));
      if ($urandom_range(0, 3) == 0) begin
        idle();
        @(posedge i_clk); #1;
      end
    end
    idle(); drain();
    check("count_max", 128'(o_count), 128'((1 << CNT_W) - 1));
    send_rand(1'b0);
    idle(); drain();
    check("count_wrap", 128'(o_count), 128'(0));

    // Reset with a full pipeline
    rdy_mode = 0;
    @(posedge i_clk); #1;
    for (int n = 0; n < DEPTH; n++) send_rand(1'(n % 2));
    idle();
    check("full_busy",  128'(o_busy),  128'(1));
    check("full_valid", 128'(o_valid), 128'(1));
    @(posedge i_clk);
    #3 i_rst_n = 1'b0;
    #1;
    check("mid_rst_valid", 128'(o_valid), 128'(0));
    check("mid_rst_busy",  128'(o_busy),  128'(0));
    check("mid_rst_data",  o_data,        128'(0));
    check("mid_rst_count", 128'(o_count), 128'(0));
    exp_q.delete();
    rdy_mode = 1;
    @(posedge i_clk); #1;
    i_rst_n = 1'b1;
    check("post_rst_in_ready", 128'(o_in_ready), 128'(1));
    repeat (10) @(posedge i_clk);
    #1;
    check("post_rst_busy", 128'(o_busy), 128'(0));

    $display("[TB] %0d tests run, %0d failed", tests, errors);
    $finish;
  end

endmodule
